// File: rtl/vga_fb_write_arbiter_pkg.sv
// Shared geometry, FSM encoding and reset colours for the frame-buffer write arbiter.
package vga_fb_write_arbiter_pkg;

  localparam int unsigned XPixels = 160;
  localparam int unsigned YPixels = 120;
  localparam int unsigned XW      = 8;
  localparam int unsigned YW      = 7;
  localparam int unsigned FbAddrW = YW + XW;

  localparam logic [XW-1:0] XLimit = XW'(XPixels);
  localparam logic [XW-1:0] XLast  = XW'(XPixels - 1);
  localparam logic [YW-1:0] YLimit = YW'(YPixels);
  localparam logic [YW-1:0] YLast  = YW'(YPixels - 1);

  localparam logic [15:0] DefaultColours = 16'hFF00;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } state_e;

endpackage

// File: rtl/vga_fb_write_arbiter_if.sv
// Requester, clear, frame-buffer and colour-config signals of the write arbiter.
interface vga_fb_write_arbiter_if;
  import vga_fb_write_arbiter_pkg::*;

  logic               req_a;
  logic [FbAddrW-1:0] addr_a;
  logic               data_a;
  logic               gnt_a;
  logic               req_b;
  logic [FbAddrW-1:0] addr_b;
  logic               data_b;
  logic               gnt_b;
  logic               clear_start;
  logic               clear_value;
  logic               clear_busy;
  logic               clear_done;
  logic               oob_err;
  logic               fb_we;
  logic [FbAddrW-1:0] fb_addr;
  logic               fb_data;
  logic [15:0]        cfg_in;
  logic               cfg_we;
  logic               vga_vs;
  logic [15:0]        config_colours;

  modport master (
    output req_a, addr_a, data_a, req_b, addr_b, data_b, clear_start, clear_value,
    output cfg_in, cfg_we, vga_vs,
    input  gnt_a, gnt_b, clear_busy, clear_done, oob_err, fb_we, fb_addr, fb_data,
    input  config_colours
  );

  modport slave (
    input  req_a, addr_a, data_a, req_b, addr_b, data_b, clear_start, clear_value,
    input  cfg_in, cfg_we, vga_vs,
    output gnt_a, gnt_b, clear_busy, clear_done, oob_err, fb_we, fb_addr, fb_data,
    output config_colours
  );

endinterface

// File: rtl/vga_fb_write_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; a requester granted last cycle is masked for one cycle.
module vga_fb_write_arbiter_rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       enable_i,
  output logic [1:0] grant_o
);

  logic [1:0] prev_q;
  logic       last_b_q, last_b_d;
  logic [1:0] elig;

  always_comb begin
    elig    = req_i & ~prev_q;
    grant_o = 2'b00;
    if (enable_i) begin
      unique case (elig)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = last_b_q ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
    end
    last_b_d = last_b_q;
    if (grant_o[1]) begin
      last_b_d = 1'b1;
    end else if (grant_o[0]) begin
      last_b_d = 1'b0;
    end
  end

  // Pointer starts at B so A wins the first contested cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q   <= 2'b00;
      last_b_q <= 1'b1;
    end else begin
      prev_q   <= grant_o;
      last_b_q <= last_b_d;
    end
  end

endmodule

// File: rtl/vga_fb_write_arbiter.sv
// Single write port of the 160x120 1-bit frame buffer: two requesters, a full-screen
// clear sequencer, and a colour register that only updates at vertical sync.
module vga_fb_write_arbiter (
  input logic                        clk_i,
  input logic                        rst_ni,
  vga_fb_write_arbiter_if.slave      bus
);
  import vga_fb_write_arbiter_pkg::*;

  state_e             state_q, state_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic               clr_val_q, clr_val_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               oob_q, oob_d;
  logic [1:0]         gnt_q, gnt_d;
  logic               we_q, we_d;
  logic [FbAddrW-1:0] addr_q, addr_d;
  logic               data_q, data_d;
  logic [15:0]        shadow_q, shadow_d;
  logic [15:0]        colours_q, colours_d;
  logic               vs_q;

  logic [1:0]         grant;
  logic               arb_en;
  logic [FbAddrW-1:0] win_addr;
  logic               win_data;
  logic               win_ok;
  logic               last_px;

  // busy_q is still high for one cycle after the last clear write; no grants then.
  assign arb_en   = (state_q == StIdle) && !busy_q && !bus.clear_start;
  assign win_addr = grant[1] ? bus.addr_b : bus.addr_a;
  assign win_data = grant[1] ? bus.data_b : bus.data_a;
  assign win_ok   = (win_addr[XW-1:0] < XLimit) && (win_addr[FbAddrW-1:XW] < YLimit);
  assign last_px  = (y_q == YLast) && (x_q == XLast);

  vga_fb_write_arbiter_rr_arbiter2 u_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    ({bus.req_b, bus.req_a}),
    .enable_i (arb_en),
    .grant_o  (grant)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!busy_q && bus.clear_start) state_d = StClear;
      StClear: if (last_px) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    clr_val_d = clr_val_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    oob_d     = 1'b0;
    gnt_d     = 2'b00;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    unique case (state_q)
      StIdle: begin
        if (busy_q) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else if (bus.clear_start) begin
          // The entry cycle already writes pixel 0, so the sweep resumes at X=1.
          busy_d    = 1'b1;
          clr_val_d = bus.clear_value;
          we_d      = 1'b1;
          addr_d    = '0;
          data_d    = bus.clear_value;
          x_d       = XW'(1);
          y_d       = '0;
        end else if (|grant) begin
          gnt_d = grant;
          if (win_ok) begin
            we_d   = 1'b1;
            addr_d = win_addr;
            data_d = win_data;
          end else begin
            oob_d = 1'b1;
          end
        end
      end
      StClear: begin
        we_d   = 1'b1;
        addr_d = {y_q, x_q};
        data_d = clr_val_q;
        if (x_q == XLast) begin
          x_d = '0;
          y_d = y_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // A CFG write in the same cycle as the sync edge reaches the active register directly.
  always_comb begin
    shadow_d  = bus.cfg_we ? bus.cfg_in : shadow_q;
    colours_d = (vs_q && !bus.vga_vs) ? shadow_d : colours_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q       <= '0;
      y_q       <= '0;
      clr_val_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      oob_q     <= 1'b0;
      gnt_q     <= 2'b00;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= 1'b0;
      shadow_q  <= DefaultColours;
      colours_q <= DefaultColours;
      vs_q      <= 1'b1;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      clr_val_q <= clr_val_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      oob_q     <= oob_d;
      gnt_q     <= gnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      shadow_q  <= shadow_d;
      colours_q <= colours_d;
      vs_q      <= bus.vga_vs;
    end
  end

  assign bus.gnt_a          = gnt_q[0];
  assign bus.gnt_b          = gnt_q[1];
  assign bus.clear_busy     = busy_q;
  assign bus.clear_done     = done_q;
  assign bus.oob_err        = oob_q;
  assign bus.fb_we          = we_q;
  assign bus.fb_addr        = addr_q;
  assign bus.fb_data        = data_q;
  assign bus.config_colours = colours_q;

endmodule

// File: tb/tb_vga_fb_write_arbiter.sv
// Self-checking bench: directed vector table, alternation, randomized traffic against a
// behavioural model, a full clear sweep and an asynchronous reset in mid-clear.
module tb_vga_fb_write_arbiter;

  localparam int Total = 160 * 120;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_fb_write_arbiter_if bus ();

  vga_fb_write_arbiter dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Behavioural model state; m_phase k (1..Total) means write k-1 of a clear is visible.
  logic        m_ga, m_gb, m_last_b, m_we, m_data, m_busy, m_done, m_oob, m_clr_val;
  logic        m_vs_prev;
  logic [14:0] m_addr;
  logic [15:0] m_shadow, m_colours;
  int          m_phase;

  typedef struct {
    logic        ra;
    logic [14:0] aa;
    logic        da;
    logic        rb;
    logic [14:0] ab;
    logic        db;
    logic        cw;
    logic [15:0] ci;
    logic        vs;
    logic [37:0] exp;
  } vec_t;

  vec_t tv[14];

  function automatic logic [37:0] pack_dut();
    return {bus.gnt_a, bus.gnt_b, bus.fb_we, bus.fb_addr, bus.fb_data, bus.clear_busy,
            bus.clear_done, bus.oob_err, bus.config_colours};
  endfunction

  function automatic logic [37:0] pack_mdl();
    return {m_ga, m_gb, m_we, m_addr, m_data, m_busy, m_done, m_oob, m_colours};
  endfunction

  function automatic logic [37:0] mk_exp(logic ga, logic gb, logic we, logic [14:0] a,
                                         logic d, logic oob, logic [15:0] col);
    return {ga, gb, we, a, d, 1'b0, 1'b0, oob, col};
  endfunction

  task automatic check(string name, logic [37:0] got, logic [37:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_ga = 0; m_gb = 0; m_last_b = 1; m_we = 0; m_addr = '0; m_data = 0;
    m_busy = 0; m_done = 0; m_oob = 0; m_clr_val = 0; m_vs_prev = 1;
    m_shadow = 16'hFF00; m_colours = 16'hFF00; m_phase = 0;
  endfunction

  // Predicts the outputs following the next rising edge from the present inputs.
  function automatic void model_step();
    logic        ea, eb, pick_a, pick_b, wd;
    logic [14:0] wa;
    int          idx;
    m_we = 0; m_oob = 0; m_done = 0;
    if (bus.cfg_we) m_shadow = bus.cfg_in;
    if (m_vs_prev && !bus.vga_vs) m_colours = m_shadow;
    m_vs_prev = bus.vga_vs;
    ea = bus.req_a && !m_ga;
    eb = bus.req_b && !m_gb;
    m_ga = 0; m_gb = 0;
    if (m_phase >= 1 && m_phase < Total) begin
      m_phase++;
    end else if (m_phase == Total) begin
      m_phase = Total + 1;
      m_done  = 1;
    end else begin
      m_phase = 0;
      if (bus.clear_start) begin
        m_phase   = 1;
        m_clr_val = bus.clear_value;
      end else begin
        pick_a = ea && (!eb || m_last_b);
        pick_b = eb && !pick_a;
        if (pick_a || pick_b) begin
          m_ga = pick_a; m_gb = pick_b; m_last_b = pick_b;
          wa = pick_a ? bus.addr_a : bus.addr_b;
          wd = pick_a ? bus.data_a : bus.data_b;
          if (wa[7:0] < 8'd160 && wa[14:8] < 7'd120) begin
            m_we = 1; m_addr = wa; m_data = wd;
          end else begin
            m_oob = 1;
          end
        end
      end
    end
    m_busy = (m_phase >= 1 && m_phase <= Total);
    if (m_busy) begin
      idx    = m_phase - 1;
      m_we   = 1;
      m_addr = {7'(idx / 160), 8'(idx % 160)};
      m_data = m_clr_val;
    end
  endfunction

  task automatic tick(string name);
    model_step();
    @(posedge clk);
    #1;
    check(name, pack_dut(), pack_mdl());
  endtask

  task automatic drive_idle();
    bus.req_a = 0; bus.addr_a = '0; bus.data_a = 0;
    bus.req_b = 0; bus.addr_b = '0; bus.data_b = 0;
    bus.clear_start = 0; bus.clear_value = 0;
    bus.cfg_in = '0; bus.cfg_we = 0; bus.vga_vs = 1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", pack_dut(), mk_exp(0, 0, 0, 15'h0, 0, 0, 16'hFF00));
    rst_n = 1;
  endtask

  function automatic logic [14:0] rand_addr();
    logic [6:0] y;
    logic [7:0] x;
    y = ($urandom_range(7) == 0) ? 7'($urandom_range(127)) : 7'($urandom_range(119));
    x = ($urandom_range(7) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(159));
    return {y, x};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          busy_cnt, we_cnt, done_cnt;
    logic [14:0] last_addr;

    //          ra    aa        da    rb    ab        db    cw    ci         vs    expected
    tv[0]  = '{1'b1, 15'h050A, 1'b1, 1'b0, 15'h0000, 1'b0, 1'b0, 16'h0000, 1'b1,
               mk_exp(1, 0, 1, 15'h050A, 1, 0, 16'hFF00)};
    tv[1]  = '{1'b1, 15'h050A, 1'b1, 1'b0, 15'h0000, 1'b0, 1'b0, 16'h0000, 1'b1,
               mk_exp(0, 0, 0, 15'h050A, 1, 0, 16'hFF00)};
    tv[2]  = '{1'b0, 15'h0000, 1'b0, 1'b1, 15'h0000, 1'b0, 1'b0, 16'h0000, 1'b1,
               mk_exp(0, 1, 1, 15'h0000, 0, 0, 16'hFF00)};
    tv[3]  = '{1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 1'b0, 1'b0, 16'h0000, 1'b1,
               mk_exp(0, 0, 0, 15'h0000, 0, 0, 16'hFF00)};
    tv[4]  = '{1'b1, 15'h7800, 1'b1, 1'b1, 15'h0102, 1'b1, 1'b0, 16'h0000, 1'b1,
               mk_exp(1, 0, 0, 15'h0000, 0, 1, 16'hFF00)};
    tv[5]  = '{1'b1, 15'h7800, 1'b1, 1'b1, 15'h0102, 1'b1, 1'b0, 16'h0000, 1'b1,
               mk_exp(0, 1, 1, 15'h0102, 1, 0, 16'hFF00)};
    tv[6]  = '{1'b1, 15'h00A0, 1'b0, 1'b1, 15'h0102, 1'b1, 1'b0, 16'h0000, 1'b1,
               mk_exp(1, 0, 0, 15'h0102, 1, 1, 16'hFF00)};
    tv[7]  = '{1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 1'b0, 1'b0, 16'h0000, 1'b1,
               mk_exp(0, 0, 0, 15'h0102, 1, 0, 16'hFF00)};
    tv[8]  = '{1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 1'b0, 1'b1, 16'h1CE3, 1'b1,
               mk_exp(0, 0, 0, 15'h0102, 1, 0, 16'hFF00)};
    tv[9]  = '{1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 1'b0, 1'b0, 16'h0000, 1'b1,
               mk_exp(0, 0, 0, 15'h0102, 1, 0, 16'hFF00)};
    tv[10] = '{1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 1'b0, 1'b0, 16'h0000, 1'b0,
               mk_exp(0, 0, 0, 15'h0102, 1, 0, 16'h1CE3)};
    tv[11] = '{1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 1'b0, 1'b1, 16'hABCD, 1'b0,
               mk_exp(0, 0, 0, 15'h0102, 1, 0, 16'h1CE3)};
    tv[12] = '{1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 1'b0, 1'b0, 16'h0000, 1'b1,
               mk_exp(0, 0, 0, 15'h0102, 1, 0, 16'h1CE3)};
    tv[13] = '{1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 1'b0, 1'b1, 16'h5A5A, 1'b0,
               mk_exp(0, 0, 0, 15'h0102, 1, 0, 16'h5A5A)};

    do_reset();
    foreach (tv[i]) begin
      bus.req_a = tv[i].ra; bus.addr_a = tv[i].aa; bus.data_a = tv[i].da;
      bus.req_b = tv[i].rb; bus.addr_b = tv[i].ab; bus.data_b = tv[i].db;
      bus.cfg_we = tv[i].cw; bus.cfg_in = tv[i].ci; bus.vga_vs = tv[i].vs;
      tick($sformatf("table_model[%0d]", i));
      check($sformatf("table[%0d]", i), pack_dut(), tv[i].exp);
    end

    // Both requesters held: grants must alternate A,B,A,B,A,B starting with A.
    do_reset();
    bus.req_a = 1; bus.addr_a = 15'h0203; bus.data_a = 1;
    bus.req_b = 1; bus.addr_b = 15'h1010; bus.data_b = 0;
    for (int i = 0; i < 6; i++) begin
      tick("alternate_model");
      check($sformatf("alternate[%0d]", i), {bus.gnt_a, bus.gnt_b, bus.fb_we},
            (i % 2 == 0) ? 38'b101 : 38'b011);
    end

    drive_idle();
    for (int c = 0; c < 3000; c++) begin
      if (bus.req_a && m_ga) bus.req_a = 0;
      else if (!bus.req_a && $urandom_range(2) == 0) begin
        bus.req_a = 1; bus.addr_a = rand_addr(); bus.data_a = ($urandom_range(1) == 1);
      end
      if (bus.req_b && m_gb) bus.req_b = 0;
      else if (!bus.req_b && $urandom_range(2) == 0) begin
        bus.req_b = 1; bus.addr_b = rand_addr(); bus.data_b = ($urandom_range(1) == 1);
      end
      bus.vga_vs = ($urandom_range(7) != 0);
      bus.cfg_we = ($urandom_range(3) == 0);
      bus.cfg_in = 16'($urandom);
      tick("random");
    end

    // Full clear started in the same cycle as a pending B request.
    drive_idle();
    tick("pre_clear");
    bus.req_b = 1; bus.addr_b = 15'h0203; bus.data_b = 1;
    bus.clear_start = 1; bus.clear_value = 0;
    tick("clear_start");
    check("clear_first", {bus.clear_busy, bus.fb_we, bus.fb_addr, bus.gnt_b},
          {1'b1, 1'b1, 15'h0000, 1'b0});
    busy_cnt = 1; we_cnt = 1; done_cnt = 0; last_addr = bus.fb_addr;
    for (int c = 0; c < Total + 100 && m_phase != Total + 1; c++) begin
      bus.clear_start = (c == 100);
      bus.clear_value = 1;
      tick("clear");
      if (bus.clear_busy) busy_cnt++;
      if (bus.clear_busy && bus.fb_we) begin
        we_cnt++;
        last_addr = bus.fb_addr;
      end
      if (bus.clear_done) done_cnt++;
    end
    check("clear_busy_cycles", 38'(busy_cnt), 38'(Total));
    check("clear_writes", 38'(we_cnt), 38'(Total));
    check("clear_last_addr", 38'(last_addr), 38'h779F);
    check("clear_done_pulses", 38'(done_cnt), 38'd1);
    tick("post_clear");
    check("gnt_b_after_clear", {bus.gnt_b, bus.fb_we, bus.fb_addr}, {1'b1, 1'b1, 15'h0203});
    bus.req_b = 0;
    tick("post_clear_idle");

    // Asynchronous reset asserted while write 5000 of a clear is on the port.
    bus.clear_start = 1; bus.clear_value = 1;
    tick("clear2_start");
    bus.clear_start = 0;
    for (int c = 0; c < 5100 && m_phase < 5000; c++) tick("clear2");
    check("clear2_reached", 38'(bus.fb_addr), 38'({7'(4999 / 160), 8'(4999 % 160)}));
    #2 rst_n = 0;
    #1;
    model_reset();
    check("async_reset", pack_dut(), mk_exp(0, 0, 0, 15'h0, 0, 0, 16'hFF00));
    @(posedge clk);
    #1;
    check("reset_held", pack_dut(), mk_exp(0, 0, 0, 15'h0, 0, 0, 16'hFF00));
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick("after_reset");
      check("after_reset_idle", {bus.fb_we, bus.clear_busy}, 38'b00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
